// File: rtl/memwb_lsu_pkg.sv
// memwb_lsu_pkg: shared data-type codes, FSM states and widths for the MEM/WB load-store unit
package memwb_lsu_pkg;

    localparam int DT_W  = 3;
    localparam int BE_W  = 4;
    localparam int CNT_W = 8;

    typedef enum logic [DT_W-1:0] {
        DT_NO     = 3'd0,
        DT_BYTE   = 3'd1,
        DT_HALF   = 3'd2,
        DT_WORD   = 3'd3,
        DT_BYTE_U = 3'd4,
        DT_HALF_U = 3'd5
    } data_type_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_e;

    // Low address bits that must be zero for an access of this size
    function automatic logic [1:0] align_mask(data_type_e dt);
        return (dt == DT_HALF || dt == DT_HALF_U) ? 2'b01 : (dt == DT_WORD) ? 2'b11 : 2'b00;
    endfunction

endpackage

// File: rtl/memwb_lsu_if.sv
// memwb_lsu_if: store data-bus req/ack handshake between the LSU and the memory side
interface memwb_lsu_if
    import memwb_lsu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
    logic            ack;

    modport master (output req, addr, wdata, be, input ack);
    modport slave  (input req, addr, wdata, be, output ack);
endinterface

// File: rtl/memwb_lsu_align.sv
// memwb_lsu_align: store lane/byte-enable generation, load lane extract/extend and misalignment detection
module memwb_lsu_align
    import memwb_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] r_data_i,
    input  logic [DT_W-1:0] data_type_i,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic            misalign_o
);

    data_type_e dt;
    logic [1:0] off;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic is_b;
    logic is_h;

    assign dt   = data_type_e'(data_type_i);
    assign off  = addr_i[1:0];
    assign is_b = (dt == DT_BYTE) || (dt == DT_BYTE_U);
    assign is_h = (dt == DT_HALF) || (dt == DT_HALF_U);

    // Lane steering for stores and loads; halves pick their lane from addr[1] only
    always_comb begin
        ld_b        = r_data_i[{off, 3'b000} +: 8];
        ld_h        = off[1] ? r_data_i[31:16] : r_data_i[15:0];
        misalign_o  = |(off & align_mask(dt));
        bus_addr_o  = {addr_i[XLEN-1:2], 2'b00};
        be_o        = is_b ? BE_W'(1) << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : (dt == DT_WORD) ? 4'b1111 : 4'b0000;
        bus_wdata_o = is_b ? {(XLEN/8){st_data_i[7:0]}} : is_h ? {(XLEN/16){st_data_i[15:0]}} : st_data_i;
        ld_data_o   = (dt == DT_BYTE)   ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                      (dt == DT_BYTE_U) ? {{(XLEN-8){1'b0}}, ld_b} :
                      (dt == DT_HALF)   ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                      (dt == DT_HALF_U) ? {{(XLEN-16){1'b0}}, ld_h} :
                      (dt == DT_WORD)   ? r_data_i : '0;
    end

endmodule

// File: rtl/memwb_lsu.sv
// memwb_lsu: MEM/WB stage -- store handshake with pipeline hold and timeout, load extraction, registered writeback
module memwb_lsu
    import memwb_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_w_reg_enable_i,
    input  logic            mem_w_reg_enable_i,
    input  logic [4:0]      w_reg_addr_i,
    input  logic [XLEN-1:0] ex_w_reg_data_i,
    input  logic [XLEN-1:0] w_mem_addr_i,
    input  logic            w_mem_enable_i,
    input  logic [XLEN-1:0] w_mem_data_i,
    input  logic [DT_W-1:0] data_type_i,
    input  logic [XLEN-1:0] r_mem_data_i,
    input  logic            ex_w_csr_enable_i,
    input  logic [11:0]     ex_w_csr_addr_i,
    input  logic [XLEN-1:0] ex_w_csr_data_i,
    memwb_lsu_if.master     bus,
    output logic            hold_req_o,
    output logic            bus_err_o,
    output logic            misalign_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            csr_w_en_o,
    output logic [11:0]     csr_w_addr_o,
    output logic [XLEN-1:0] csr_w_data_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic req_q, req_d, err_q, err_d, mis_q, mis_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic wb_en_q, wb_en_d, csr_en_q, csr_en_d;
    logic [4:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d, csr_data_q, csr_data_d;
    logic [11:0] csr_addr_q, csr_addr_d;

    logic [XLEN-1:0] al_addr, al_wdata, ld_data;
    logic [BE_W-1:0] al_be;
    logic al_mis, misaligned, last;

    memwb_lsu_align #(.XLEN(XLEN)) u_align (
        .addr_i      (w_mem_addr_i),
        .st_data_i   (w_mem_data_i),
        .r_data_i    (r_mem_data_i),
        .data_type_i (data_type_i),
        .bus_addr_o  (al_addr),
        .bus_wdata_o (al_wdata),
        .be_o        (al_be),
        .ld_data_o   (ld_data),
        .misalign_o  (al_mis)
    );

    assign misaligned = al_mis & (w_mem_enable_i | mem_w_reg_enable_i);
    assign last       = cnt_q == TMO_LAST;

    // Store FSM: launch an aligned store, hold the pipeline until ack or timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        err_d      = 1'b0;
        hold_req_o = 1'b0;
        mis_d      = misaligned & (state_q == S_IDLE);
        if (state_q == S_IDLE) begin
            if (w_mem_enable_i && !al_mis) begin
                hold_req_o = 1'b1;
                state_d    = S_WAIT_ACK;
                cnt_d      = '0;
                req_d      = 1'b1;
                addr_d     = al_addr;
                wdata_d    = al_wdata;
                be_d       = al_be;
            end
        end else begin
            hold_req_o = ~bus.ack & ~last;
            cnt_d      = cnt_q + 1'b1;
            if (bus.ack || last) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                err_d   = ~bus.ack;
            end
        end
    end

    // Writeback next state: bubble while holding, load result beats EX result, stores suppress the write
    always_comb begin
        wb_en_d    = ~hold_req_o & (ex_w_reg_enable_i | mem_w_reg_enable_i) & (|w_reg_addr_i) & ~misaligned & ~w_mem_enable_i;
        wb_addr_d  = hold_req_o ? wb_addr_q : w_reg_addr_i;
        wb_data_d  = hold_req_o ? wb_data_q : mem_w_reg_enable_i ? ld_data : ex_w_reg_data_i;
        csr_en_d   = ~hold_req_o & ex_w_csr_enable_i;
        csr_addr_d = hold_req_o ? csr_addr_q : ex_w_csr_addr_i;
        csr_data_d = hold_req_o ? csr_data_q : ex_w_csr_data_i;
    end

    // Bus-side state and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Register-file and CSR writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            csr_en_q   <= 1'b0;
            csr_addr_q <= '0;
            csr_data_q <= '0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            csr_en_q   <= csr_en_d;
            csr_addr_q <= csr_addr_d;
            csr_data_q <= csr_data_d;
        end
    end

    assign bus.req      = req_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.be       = be_q;
    assign bus_err_o    = err_q;
    assign misalign_o   = mis_q;
    assign wb_en_o      = wb_en_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign csr_w_en_o   = csr_en_q;
    assign csr_w_addr_o = csr_addr_q;
    assign csr_w_data_o = csr_data_q;

endmodule

// File: doc/memwb_lsu.md
Name: memwb_lsu

Overview:
- Consumer side of the EX->MEM/WB pipeline register; sits directly after it in the core.
- Performs stores over a req/ack data-bus handshake, and requests a pipeline hold while a store is outstanding.
- Extracts and sign/zero-extends BRAM load data, whose read was issued in EX.
- Registers the final register-file and CSR writeback, one cycle after the instruction arrives.

Parameters:
- TIMEOUT, 16, cycles in WAIT_ACK without bus_ack_i before the store is abandoned (legal range 2..255).
- XLEN, 32, data/address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ex_w_reg_enable_i  in  1  write EX result to the register file.
- mem_w_reg_enable_i  in  1  write load result to the register file.
- w_reg_addr_i  in  5  destination register.
- ex_w_reg_data_i  in  XLEN  EX result.
- w_mem_addr_i  in  XLEN  store address; for loads, bits [1:0] are the load byte offset.
- w_mem_enable_i  in  1  store request.
- w_mem_data_i  in  XLEN  store data, right-aligned.
- data_type_i  in  3  access size/sign (shared codes).
- r_mem_data_i  in  XLEN  BRAM word read data, valid in the cycle the load is presented.
- ex_w_csr_enable_i / ex_w_csr_addr_i / ex_w_csr_data_i  in  1/12/XLEN  CSR write.
- bus_req_o  out  1  store request.
- bus_addr_o  out  XLEN  word-aligned store address.
- bus_wdata_o  out  XLEN  lane-replicated store data.
- bus_be_o  out  4  byte enables.
- bus_ack_i  in  1  store accepted.
- hold_req_o  out  1  hold the EX/MEMWB register and everything upstream.
- bus_err_o  out  1  one-cycle pulse on store timeout.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- wb_en_o / wb_addr_o / wb_data_o  out  1/5/XLEN  registered register-file write.
- csr_w_en_o / csr_w_addr_o / csr_w_data_o  out  1/12/XLEN  registered CSR write.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; timeout counter clears.
  - All registered outputs go to 0: bus_req_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_err_o, misalign_o, wb_*, csr_*.
  - An outstanding store is dropped without an error pulse.
- FSM states: IDLE, WAIT_ACK.
- IDLE, store with w_mem_enable_i=1 and aligned address:
  - hold_req_o=1 combinationally in the same cycle.
  - At the next edge, bus_req_o=1 with addr/wdata/be latched; state goes to WAIT_ACK; counter=0.
- WAIT_ACK:
  - Outputs held stable.
  - hold_req_o = ~bus_ack_i; counter increments each cycle.
  - On bus_ack_i=1: state goes to IDLE and bus_req_o=0 at the same edge. Because hold was released in the ack cycle, the pipeline register advances at that edge and the store is never re-issued.
  - If the counter reaches TIMEOUT-1 with no ack: bus_req_o=0, bus_err_o pulses for 1 cycle, state goes to IDLE, and hold_req_o=0 in that final cycle.
  - A bus_ack_i arriving in the same cycle as the timeout counts as success: no error.
- Store lane generation:
  - Byte: be = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - Word: be = 1111.
  - bus_addr_o = {addr[XLEN-1:2], 2'b00}.
- Misalignment:
  - Condition: half with addr[0]=1, or word with addr[1:0]!=0, on a store or a load.
  - Store: no bus request, no hold, no register write.
  - misalign_o pulses at the next edge.
- Load extraction (mem_w_reg_enable_i=1):
  - Select the byte/half lane of r_mem_data_i using w_mem_addr_i[1:0].
  - Sign- or zero-extend per data_type_i.
  - datatype_no with a load enabled: write zero.
- Writeback, registered, 1-cycle latency, updated only when hold_req_o=0:
  - wb_en_o <= (ex_w_reg_enable_i | mem_w_reg_enable_i) & (w_reg_addr_i != 0) & ~misaligned.
  - If both enables are set, the load result wins.
  - While hold_req_o=1, wb_en_o<=0 and csr_w_en_o<=0 (bubble); addr/data hold their last values.
  - CSR outputs are registered under the same rule and are independent of the register writeback.
- Simultaneous store and register write in one instruction: not legal; the store takes precedence and the write is suppressed.

Decomposition:
- Shared define file:
  - data-type codes: datatype_no=0, byte=1, half=2, word=3, byte_u=4, half_u=5.
  - data_type bus width (3).
  - FSM state codes.
  - be width (4).
- One combinational sub-module, lsu_align, does store lane/be generation, load extract/extend, and the misalign flag.
- The FSM, timeout counter and writeback registers stay in memwb_lsu.

Test Plan:
- Store byte: addr 0x1003, data 0xAB, ack after 3 wait cycles -> be=1000, wdata=0xABABABAB, bus_addr=0x1000; hold_req_o high for exactly 4 cycles; a single request.
- Store word, bus_ack_i never asserted, TIMEOUT=16 -> bus_req_o drops after 16 cycles, bus_err_o pulses once, hold released.
- Load byte signed: addr[1:0]=2, r_mem_data_i=0x00800000, rd=5 -> next cycle wb_en_o=1, wb_addr_o=5, wb_data_o=0xFFFFFF80; half_u at addr[1:0]=2 on 0x80010000 -> 0x00008001.
- Misaligned word store at 0x2002 -> no bus_req_o, no hold, misalign_o pulses once, wb_en_o=0.
- EX write to x0 with data 0x1234 -> wb_en_o=0; EX write to x7 during a store hold -> delivered one cycle after hold_req_o falls.
- rst asserted in WAIT_ACK -> next edge bus_req_o=0, state IDLE, bus_err_o=0, all wb/csr outputs 0.
